// File: rtl/evm_pkg.sv
// Shared types and helpers for the electronic voting machine ballot controller.
package evm_pkg;

   typedef enum logic [1:0] {
      CHECK   = 2'd0,
      ARMED   = 2'd1,
      LOCKOUT = 2'd2,
      SEALED  = 2'd3
   } evm_state_e;

   // Width needed to index n items; never returns less than one bit.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/evm_tally_bank.sv
// Bank of NUM_CAND saturating vote counters with a single increment port and one read port.
module evm_tally_bank
   import evm_pkg::*;
#(
   parameter int NUM_CAND = 4,
   parameter int CNT_W    = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       inc_en,
   input  logic [clog2(NUM_CAND)-1:0] inc_idx,
   input  logic [clog2(NUM_CAND)-1:0] rd_sel,
   output logic [CNT_W-1:0]           rd_data,
   output logic                       sat
);

   localparam int                IDX_W   = clog2(NUM_CAND);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;
   localparam logic [CNT_W-1:0]  CNT_M1  = CNT_MAX - 1'b1;

   logic [CNT_W-1:0] tally_q [NUM_CAND];
   logic [CNT_W-1:0] tally_d [NUM_CAND];

   // sat flags any counted vote that leaves its tally pinned at the maximum.
   always_comb begin
      sat = 1'b0;
      for (int i = 0; i < NUM_CAND; i++) begin
         tally_d[i] = tally_q[i];
         if (inc_en && (inc_idx == IDX_W'(i))) begin
            if (tally_q[i] != CNT_MAX) tally_d[i] = tally_q[i] + 1'b1;
            if (tally_q[i] >= CNT_M1) sat = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= tally_d[i];
      end
   end

   // Selects beyond the last candidate fall through to zero.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
         if (rd_sel == IDX_W'(i)) rd_data = tally_q[i];
      end
   end

endmodule

// File: rtl/evm_ballot_controller.sv
// Ballot controller: one vote per officer authorisation, button-release lockout,
// saturating tallies and a terminal seal with read-only result access.
module evm_ballot_controller
   import evm_pkg::*;
#(
   parameter int NUM_CAND       = 4,
   parameter int CNT_W          = 16,
   parameter int LOCKOUT_CYCLES = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       officer_auth,
   input  logic [NUM_CAND-1:0]        push,
   input  logic                       seal_req,
   input  logic [clog2(NUM_CAND)-1:0] rd_sel,
   output logic                       ready_led,
   output logic                       vote_valid,
   output logic [clog2(NUM_CAND)-1:0] vote_idx,
   output logic                       multi_err,
   output logic                       sealed,
   output logic                       sat_flag,
   output logic [CNT_W-1:0]           rd_count
);

   localparam int IDX_W = clog2(NUM_CAND);
   localparam int LK_W  = clog2(LOCKOUT_CYCLES + 1);

   evm_state_e       state_q, state_d;
   logic [LK_W-1:0]  lk_q, lk_d;
   logic             push_none, push_one;
   logic [IDX_W-1:0] push_idx;
   logic             accept, multi;
   logic             ready_q, valid_q, multi_q, sealed_q, sat_q;
   logic [IDX_W-1:0] idx_q;
   logic             bank_sat;
   logic [CNT_W-1:0] rd_data;

   always_comb begin
      push_none = (push == '0);
      push_one  = !push_none && ((push & (push - 1'b1)) == '0);
      push_idx  = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
         if (push[i]) push_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CHECK;
         lk_q    <= '0;
      end else begin
         state_q <= state_d;
         lk_q    <= lk_d;
      end
   end

   // LOCKOUT is left only after the counter has drained and every button is released.
   always_comb begin
      state_d = state_q;
      lk_d    = lk_q;
      case (state_q)
         CHECK: begin
            if (seal_req)          state_d = SEALED;
            else if (officer_auth) state_d = ARMED;
         end
         ARMED: begin
            if (seal_req) begin
               state_d = SEALED;
            end else if (push_one) begin
               state_d = LOCKOUT;
               lk_d    = LK_W'(LOCKOUT_CYCLES);
            end
         end
         LOCKOUT: begin
            if ((lk_q == '0) && push_none) state_d = CHECK;
            else if (lk_q != '0)           lk_d    = lk_q - 1'b1;
         end
         SEALED:  state_d = SEALED;
         default: state_d = CHECK;
      endcase
   end

   always_comb begin
      accept = 1'b0;
      multi  = 1'b0;
      if ((state_q == ARMED) && !seal_req) begin
         accept = push_one;
         multi  = !push_none && !push_one;
      end
   end

   // Outputs are registered from the next state so they line up with the state change.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready_q  <= 1'b0;
         valid_q  <= 1'b0;
         multi_q  <= 1'b0;
         sealed_q <= 1'b0;
         sat_q    <= 1'b0;
         idx_q    <= '0;
      end else begin
         ready_q  <= (state_d == ARMED);
         valid_q  <= accept;
         multi_q  <= multi;
         sealed_q <= (state_d == SEALED);
         sat_q    <= sat_q | bank_sat;
         if (accept) idx_q <= push_idx;
      end
   end

   evm_tally_bank #(
      .NUM_CAND (NUM_CAND),
      .CNT_W    (CNT_W)
   ) u_tally (
      .clk      (clk),
      .reset    (reset),
      .inc_en   (accept),
      .inc_idx  (push_idx),
      .rd_sel   (rd_sel),
      .rd_data  (rd_data),
      .sat      (bank_sat)
   );

   assign ready_led  = ready_q;
   assign vote_valid = valid_q;
   assign vote_idx   = idx_q;
   assign multi_err  = multi_q;
   assign sealed     = sealed_q;
   assign sat_flag   = sat_q;
   assign rd_count   = sealed_q ? rd_data : '0;

endmodule

// File: tb/tb_evm_ballot_controller.sv
// Self-checking bench: a directed vector table plus hand-written multi-cycle sequences,
// run on a 16-bit tally instance and a 2-bit tally instance driven in lockstep.
module tb_evm_ballot_controller;

   logic        clk;
   logic        reset;
   logic        officerAuth;
   logic [3:0]  push;
   logic        sealReq;
   logic [1:0]  rdSel;

   logic        readyLed, voteValid, multiErr, sealedOut, satFlag;
   logic [1:0]  voteIdx;
   logic [15:0] rdCount;

   logic        readyLed2, voteValid2, multiErr2, sealedOut2, satFlag2;
   logic [1:0]  voteIdx2;
   logic [1:0]  rdCount2;

   int checks = 0;
   int fails  = 0;
   int candList [5];

   typedef struct {
      logic        auth;
      logic [3:0]  push;
      logic        seal;
      logic [1:0]  rdSel;
      logic        eReady;
      logic        eValid;
      logic [1:0]  eIdx;
      logic        eMulti;
      logic        eSealed;
      logic [15:0] eCount;
   } vec_t;

   vec_t vecs [26];

   evm_ballot_controller #(.NUM_CAND(4), .CNT_W(16), .LOCKOUT_CYCLES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .officer_auth (officerAuth),
      .push         (push),
      .seal_req     (sealReq),
      .rd_sel       (rdSel),
      .ready_led    (readyLed),
      .vote_valid   (voteValid),
      .vote_idx     (voteIdx),
      .multi_err    (multiErr),
      .sealed       (sealedOut),
      .sat_flag     (satFlag),
      .rd_count     (rdCount)
   );

   evm_ballot_controller #(.NUM_CAND(4), .CNT_W(2), .LOCKOUT_CYCLES(4)) dutSat (
      .clk          (clk),
      .reset        (reset),
      .officer_auth (officerAuth),
      .push         (push),
      .seal_req     (sealReq),
      .rd_sel       (rdSel),
      .ready_led    (readyLed2),
      .vote_valid   (voteValid2),
      .vote_idx     (voteIdx2),
      .multi_err    (multiErr2),
      .sealed       (sealedOut2),
      .sat_flag     (satFlag2),
      .rd_count     (rdCount2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic a, input logic [3:0] p, input logic sr, input logic [1:0] rs,
                               input logic r, input logic v, input logic [1:0] ix, input logic m,
                               input logic se, input logic [15:0] c);
      vec_t t;
      t.auth = a;  t.push = p;    t.seal = sr;   t.rdSel = rs;
      t.eReady = r; t.eValid = v; t.eIdx = ix;  t.eMulti = m;
      t.eSealed = se; t.eCount = c;
      return t;
   endfunction

   task automatic applyReset();
      reset = 1'b1; officerAuth = 1'b0; push = '0; sealReq = 1'b0; rdSel = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic applyStimulus(input int row);
      @(negedge clk);
      officerAuth = vecs[row].auth;
      push        = vecs[row].push;
      sealReq     = vecs[row].seal;
      rdSel       = vecs[row].rdSel;
      @(posedge clk);
      #1;
      checkOutput($sformatf("row%0d ready_led", row),  readyLed,  vecs[row].eReady);
      checkOutput($sformatf("row%0d vote_valid", row), voteValid, vecs[row].eValid);
      checkOutput($sformatf("row%0d vote_idx", row),   voteIdx,   vecs[row].eIdx);
      checkOutput($sformatf("row%0d multi_err", row),  multiErr,  vecs[row].eMulti);
      checkOutput($sformatf("row%0d sealed", row),     sealedOut, vecs[row].eSealed);
      checkOutput($sformatf("row%0d rd_count", row),   rdCount,   vecs[row].eCount);
   endtask

   // Press candList[k] whenever the panel shows ready; stop after n pulses or a cycle budget.
   task automatic runVotes(input int n, output int pulses, output int minGap, output int pulses2);
      int sent;
      int lastCyc;
      int cyc;
      sent = 0; lastCyc = -1; cyc = 0;
      pulses = 0; pulses2 = 0; minGap = 1000;
      while ((pulses < n) && (cyc < 200)) begin
         @(negedge clk);
         if (readyLed && (sent < n)) begin
            push = 4'(1 << candList[sent]);
            sent++;
         end else begin
            push = '0;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (voteValid) begin
            pulses++;
            if ((lastCyc >= 0) && ((cyc - lastCyc) < minGap)) minGap = cyc - lastCyc;
            lastCyc = cyc;
         end
         if (voteValid2) pulses2++;
      end
      @(negedge clk);
      push = '0;
   endtask

   task automatic sealAndWait(input string tag);
      int cyc;
      cyc = 0;
      @(negedge clk);
      sealReq = 1'b1;
      while (!sealedOut && (cyc < 30)) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checkOutput({tag, " sealed reached"}, sealedOut, 1'b1);
   endtask

   task automatic readTally(input string tag, input logic [1:0] sel, input logic [15:0] exp, input logic [1:0] exp2);
      @(negedge clk);
      rdSel = sel;
      #1;
      checkOutput($sformatf("%s rd_count[%0d]", tag, sel), rdCount, exp);
      checkOutput($sformatf("%s sat rd_count[%0d]", tag, sel), rdCount2, exp2);
   endtask

   initial begin
      int pulses, minGap, pulses2;

      for (int i = 0; i < 26; i++) vecs[i] = mk(0, 4'b0000, 0, 2'd0, 0, 0, 2'd0, 0, 0, 16'd0);
      vecs[0]  = mk(1, 4'b0000, 0, 2'd0, 1, 0, 2'd0, 0, 0, 16'd0);
      vecs[1]  = mk(0, 4'b0011, 0, 2'd0, 1, 0, 2'd0, 1, 0, 16'd0);
      vecs[2]  = mk(0, 4'b0000, 0, 2'd2, 1, 0, 2'd0, 0, 0, 16'd0);
      vecs[3]  = mk(0, 4'b0100, 0, 2'd2, 0, 1, 2'd2, 0, 0, 16'd0);
      for (int i = 4; i <= 12; i++) vecs[i] = mk(0, 4'b0100, 0, 2'd2, 0, 0, 2'd2, 0, 0, 16'd0);
      vecs[13] = mk(1, 4'b0000, 0, 2'd2, 0, 0, 2'd2, 0, 0, 16'd0);
      vecs[14] = mk(1, 4'b0000, 0, 2'd2, 1, 0, 2'd2, 0, 0, 16'd0);
      vecs[15] = mk(0, 4'b0001, 0, 2'd2, 0, 1, 2'd0, 0, 0, 16'd0);
      for (int i = 16; i <= 20; i++) vecs[i] = mk(1, 4'b0000, 0, 2'd2, 0, 0, 2'd0, 0, 0, 16'd0);
      vecs[21] = mk(1, 4'b0000, 0, 2'd2, 1, 0, 2'd0, 0, 0, 16'd0);
      vecs[22] = mk(1, 4'b1000, 1, 2'd2, 0, 0, 2'd0, 0, 1, 16'd1);
      vecs[23] = mk(1, 4'b0001, 0, 2'd0, 0, 0, 2'd0, 0, 1, 16'd1);
      vecs[24] = mk(1, 4'b0100, 1, 2'd1, 0, 0, 2'd0, 0, 1, 16'd0);
      vecs[25] = mk(0, 4'b0000, 0, 2'd3, 0, 0, 2'd0, 0, 1, 16'd0);

      reset = 1'b1; officerAuth = 1'b0; push = '0; sealReq = 1'b0; rdSel = '0;
      #12;
      checkOutput("reset ready_led", readyLed, 1'b0);
      checkOutput("reset vote_valid", voteValid, 1'b0);
      checkOutput("reset vote_idx", voteIdx, 2'd0);
      checkOutput("reset multi_err", multiErr, 1'b0);
      checkOutput("reset sealed", sealedOut, 1'b0);
      checkOutput("reset sat_flag", satFlag, 1'b0);
      checkOutput("reset rd_count", rdCount, 16'd0);
      applyReset();

      for (int r = 0; r < 26; r++) applyStimulus(r);

      // Authorisation held high: every vote still needs its own pass through CHECK.
      applyReset();
      officerAuth = 1'b1;
      candList[0] = 0; candList[1] = 1; candList[2] = 3;
      runVotes(3, pulses, minGap, pulses2);
      checkOutput("held auth pulse count", pulses, 3);
      checkOutput("held auth spacing >= 7", (minGap >= 7), 1'b1);
      checkOutput("held auth last vote_idx", voteIdx, 2'd3);
      sealAndWait("held auth");
      readTally("held auth", 2'd0, 16'd1, 2'd1);
      readTally("held auth", 2'd1, 16'd1, 2'd1);
      readTally("held auth", 2'd2, 16'd0, 2'd0);
      readTally("held auth", 2'd3, 16'd1, 2'd1);
      checkOutput("held auth sat_flag", satFlag2, 1'b0);

      // Five votes for one candidate saturate the 2-bit instance at 3.
      applyReset();
      officerAuth = 1'b1;
      for (int i = 0; i < 5; i++) candList[i] = 1;
      runVotes(5, pulses, minGap, pulses2);
      checkOutput("saturate pulse count", pulses, 5);
      checkOutput("saturate narrow pulse count", pulses2, 5);
      sealAndWait("saturate");
      readTally("saturate", 2'd1, 16'd5, 2'd3);
      readTally("saturate", 2'd0, 16'd0, 2'd0);
      checkOutput("saturate narrow sat_flag", satFlag2, 1'b1);
      checkOutput("saturate wide sat_flag", satFlag, 1'b0);

      // Reset landing in the middle of LOCKOUT clears everything straight away.
      applyReset();
      officerAuth = 1'b1;
      candList[0] = 0; candList[1] = 3;
      runVotes(2, pulses, minGap, pulses2);
      checkOutput("pre-reset pulse count", pulses, 2);
      checkOutput("pre-reset vote_idx", voteIdx, 2'd3);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("mid-lockout reset ready_led", readyLed, 1'b0);
      checkOutput("mid-lockout reset vote_valid", voteValid, 1'b0);
      checkOutput("mid-lockout reset vote_idx", voteIdx, 2'd0);
      checkOutput("mid-lockout reset multi_err", multiErr, 1'b0);
      checkOutput("mid-lockout reset sealed", sealedOut, 1'b0);
      checkOutput("mid-lockout reset sat_flag", satFlag, 1'b0);
      checkOutput("mid-lockout reset rd_count", rdCount, 16'd0);
      @(negedge clk);
      reset = 1'b0;
      officerAuth = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("post-reset idle ready_led", readyLed, 1'b0);
      @(negedge clk);
      officerAuth = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post-reset arms from CHECK", readyLed, 1'b1);
      sealAndWait("post-reset");
      for (int c = 0; c < 4; c++) readTally("post-reset", 2'(c), 16'd0, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
